// File: rtl/cheri_err_led_pkg.sv
// Shared types and cause indices for the CHERI error LED driver.
package cheri_err_led_pkg;

    typedef enum logic [1:0] {
        ChanIdle   = 2'd0,
        ChanBright = 2'd1,
        ChanDim    = 2'd2
    } chan_state_e;

    localparam int unsigned ErrBounds           = 0;
    localparam int unsigned ErrTag              = 1;
    localparam int unsigned ErrSeal             = 2;
    localparam int unsigned ErrPermitEx         = 3;
    localparam int unsigned ErrPermitLd         = 4;
    localparam int unsigned ErrPermitSt         = 5;
    localparam int unsigned ErrPermitStCap      = 6;
    localparam int unsigned ErrPermitStLocalCap = 7;
    localparam int unsigned ErrPermitAccSysRegs = 8;

    // Index of the lowest set bit; 0 when no bit is set. Supports up to 32 causes.
    function automatic int unsigned lowest_set(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/cheri_err_led_chan.sv
// One LED channel: idle / full-brightness hold / dim PWM, retriggered by events.
module cheri_err_led_chan
    import cheri_err_led_pkg::*;
#(
    parameter int unsigned HoldCycles = 19_000_000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        event_i,
    input  logic        clear_i,
    input  logic        pwm_on_i,
    output logic        led_o,
    output chan_state_e state_next_o
);

    localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
    localparam logic [HoldW-1:0] HoldReload = HoldW'(HoldCycles - 1);

    chan_state_e      state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;

    // An event always wins over a coincident clear so no exception goes unseen.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (event_i) begin
            state_d = ChanBright;
            hold_d  = HoldReload;
        end else if (clear_i) begin
            state_d = ChanIdle;
            hold_d  = '0;
        end else begin
            case (state_q)
                ChanBright: begin
                    if (hold_q == '0) begin
                        state_d = ChanDim;
                    end else begin
                        hold_d = hold_q - HoldW'(1);
                    end
                end
                ChanIdle, ChanDim: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ChanIdle;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ChanIdle;
            hold_q  <= '0;
            led_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            case (state_d)
                ChanBright: led_o <= 1'b1;
                ChanDim:    led_o <= pwm_on_i;
                default:    led_o <= 1'b0;
            endcase
        end
    end

    assign state_next_o = state_d;

endmodule

// File: rtl/cheri_err_led_driver.sv
// CHERI exception LED driver: shared PWM, per-cause channels, first-cause capture.
module cheri_err_led_driver
    import cheri_err_led_pkg::*;
#(
    parameter int unsigned ErrWidth   = 9,
    parameter int unsigned HoldCycles = 19_000_000,
    parameter int unsigned PwmPeriod  = 256,
    parameter int unsigned DimDuty    = 32,
    localparam int unsigned IdxW      = (ErrWidth > 1) ? $clog2(ErrWidth) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ErrWidth-1:0] err_pulse_i,
    input  logic                clear_i,
    output logic [ErrWidth-1:0] led_o,
    output logic                err_any_o,
    output logic                first_valid_o,
    output logic [IdxW-1:0]     first_idx_o
);

    localparam int unsigned PwmW = $clog2(PwmPeriod);

    logic [PwmW-1:0] pwm_q, pwm_d;
    logic            pwm_on;
    chan_state_e     chan_next [ErrWidth];
    logic            any_next;
    logic            any_event;
    logic [IdxW-1:0] lowest_idx;

    // LEDs are registered from next state, so they compare against the next count.
    assign pwm_d  = (pwm_q == PwmW'(PwmPeriod - 1)) ? '0 : pwm_q + PwmW'(1);
    assign pwm_on = 32'(pwm_d) < DimDuty;

    for (genvar g = 0; g < ErrWidth; g++) begin : g_chan
        cheri_err_led_chan #(
            .HoldCycles(HoldCycles)
        ) u_chan (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .event_i     (err_pulse_i[g]),
            .clear_i     (clear_i),
            .pwm_on_i    (pwm_on),
            .led_o       (led_o[g]),
            .state_next_o(chan_next[g])
        );
    end

    always_comb begin
        any_next = 1'b0;
        for (int i = 0; i < ErrWidth; i++) begin
            if (chan_next[i] != ChanIdle) begin
                any_next = 1'b1;
            end
        end
    end

    assign any_event  = |err_pulse_i;
    assign lowest_idx = IdxW'(lowest_set(32'(err_pulse_i)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pwm_q         <= '0;
            err_any_o     <= 1'b0;
            first_valid_o <= 1'b0;
            first_idx_o   <= '0;
        end else begin
            pwm_q     <= pwm_d;
            err_any_o <= any_next;
            // A clear with coincident events recaptures from those events.
            if (clear_i) begin
                first_valid_o <= any_event;
                first_idx_o   <= any_event ? lowest_idx : '0;
            end else if (!first_valid_o && any_event) begin
                first_valid_o <= 1'b1;
                first_idx_o   <= lowest_idx;
            end
        end
    end

endmodule

// File: tb/tb_cheri_err_led_driver.sv
// Scoreboard bench for cheri_err_led_driver with a cycle-level reference model.
module tb_cheri_err_led_driver;

    localparam int N    = 9;
    localparam int HOLD = 10;
    localparam int PER  = 8;
    localparam int DUTY = 2;
    localparam int W    = N + 1 + 1 + 4;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic [N-1:0] err_pulse = '0;
    logic         clear = 1'b0;
    logic [N-1:0] led;
    logic         err_any;
    logic         first_valid;
    logic [3:0]   first_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state: remaining bright cycles and lit flag per cause.
    int rem [N];
    bit lit [N];
    bit m_valid;
    int m_idx;
    int edge_cnt;

    cheri_err_led_driver #(
        .ErrWidth  (N),
        .HoldCycles(HOLD),
        .PwmPeriod (PER),
        .DimDuty   (DUTY)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .err_pulse_i  (err_pulse),
        .clear_i      (clear),
        .led_o        (led),
        .err_any_o    (err_any),
        .first_valid_o(first_valid),
        .first_idx_o  (first_idx)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Model: predicts the outputs that follow each rising edge.
    always @(posedge clk) begin
        logic [N-1:0] m_led;
        bit           m_any;
        int           low;
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) begin
                rem[i] = 0;
                lit[i] = 0;
            end
            m_valid  = 0;
            m_idx    = 0;
            edge_cnt = 0;
            exp_q.push_back('0);
        end else begin
            edge_cnt++;
            m_led = '0;
            m_any = 0;
            for (int i = 0; i < N; i++) begin
                if (err_pulse[i]) begin
                    lit[i] = 1;
                    rem[i] = HOLD;
                end else if (clear) begin
                    lit[i] = 0;
                    rem[i] = 0;
                end
                if (rem[i] > 0) begin
                    m_led[i] = 1'b1;
                    rem[i]--;
                end else begin
                    m_led[i] = lit[i] && ((edge_cnt % PER) < DUTY);
                end
                if (lit[i]) m_any = 1;
            end
            low = 0;
            for (int i = N - 1; i >= 0; i--) if (err_pulse[i]) low = i;
            if (clear) begin
                m_valid = (err_pulse != 0);
                m_idx   = (err_pulse != 0) ? low : 0;
            end else if (!m_valid && err_pulse != 0) begin
                m_valid = 1;
                m_idx   = low;
            end
            exp_q.push_back({m_led, m_any, m_valid, 4'(m_idx)});
        end
    end

    // Monitor: compares DUT outputs away from the active edge.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {led, err_any, first_valid, first_idx};
            n_checks++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got led=%b any=%b valid=%b idx=%0d, want led=%b any=%b valid=%b idx=%0d",
                         $time, act_v[W-1-:N], act_v[5], act_v[4], act_v[3:0],
                         exp_v[W-1-:N], exp_v[5], exp_v[4], exp_v[3:0]);
            end
        end
    end

    // Driver tasks
    task automatic step(input logic [N-1:0] p, input logic c);
        err_pulse = p;
        clear     = c;
        @(posedge clk);
        #1;
        err_pulse = '0;
        clear     = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_now(input string name, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got=%b want=%b", name, act, want);
        end
    endtask

    initial begin
        logic [N-1:0] p;
        #12 rst_ni = 1'b1;
        @(posedge clk);
        #1;

        idle(50);

        step(9'(1 << 1), 1'b0);
        idle(30);
        step('0, 1'b1);
        idle(3);

        step(9'(1 << 0), 1'b0);
        idle(6);
        step(9'(1 << 0), 1'b0);
        idle(25);
        step('0, 1'b1);
        idle(2);

        step(9'((1 << 5) | (1 << 3)), 1'b0);
        idle(4);
        step(9'(1 << 0), 1'b0);
        idle(5);
        step('0, 1'b1);
        idle(2);

        step(9'(1 << 2), 1'b0);
        idle(15);
        step(9'(1 << 8), 1'b1);
        step('0, 1'b1);
        idle(5);

        // Asynchronous reset while channel 4 is in its bright hold.
        step(9'(1 << 4), 1'b0);
        idle(3);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check_now("reset_led4", led[4], 1'b0);
        check_now("reset_any", err_any, 1'b0);
        check_now("reset_valid", first_valid, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        idle(15);

        for (int k = 0; k < 400; k++) begin
            p = '0;
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 15) == 0) p[b] = 1'b1;
            end
            step(p, ($urandom_range(0, 24) == 0));
        end
        idle(3);
        @(negedge clk);
        #1;

        n_checks++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL queue_drain got=%0d want<=1", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
